// File: rtl/params.sv
// Shared types and constants for the RV32I decode stage: datapath word,
// ALU operand selects and op-codes, RV32I major opcodes and the packed
// control bundle that the decoder hands to execute.
package params;

   localparam int XLEN_C = 32;

   typedef logic [XLEN_C-1:0] word;

   // Encoding 0 is ADD so an all-zero bundle is a harmless ADD.
   typedef enum logic [3:0] {
      OP_ALU_ADD  = 4'd0,
      OP_ALU_SUB  = 4'd1,
      OP_ALU_SLL  = 4'd2,
      OP_ALU_SLT  = 4'd3,
      OP_ALU_SLTU = 4'd4,
      OP_ALU_XOR  = 4'd5,
      OP_ALU_SRL  = 4'd6,
      OP_ALU_SRA  = 4'd7,
      OP_ALU_OR   = 4'd8,
      OP_ALU_AND  = 4'd9
   } alu_op_t;

   // Operand-1 source: register file or the instruction's PC.
   typedef enum logic {
      ALU_RS1_OP = 1'b0,
      ALU_PC_OP  = 1'b1
   } alu_rs1_t;

   // Operand-2 source: register file or the decoded immediate.
   typedef enum logic {
      ALU_RS2_OP = 1'b0,
      ALU_IMM_OP = 1'b1
   } alu_rs2_t;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      word        pc;
      word        imm;
      alu_rs1_t   alu_rs1;
      alu_rs2_t   alu_rs2;
      alu_op_t    alu_op;
      logic [4:0] rs1_idx;
      logic [4:0] rs2_idx;
      logic [4:0] rd_idx;
      logic       rd_we;
      logic       illegal;
   } decode_bundle_t;

   // funct3 to ALU op; alt selects SUB/SRA on the two funct3 codes that
   // have an alternate form and is ignored elsewhere.
   function automatic alu_op_t funct3_to_op(input logic [2:0] funct3, input logic alt);
      alu_op_t op;
      case (funct3)
         3'b000:  op = alt ? OP_ALU_SUB : OP_ALU_ADD;
         3'b001:  op = OP_ALU_SLL;
         3'b010:  op = OP_ALU_SLT;
         3'b011:  op = OP_ALU_SLTU;
         3'b100:  op = OP_ALU_XOR;
         3'b101:  op = alt ? OP_ALU_SRA : OP_ALU_SRL;
         3'b110:  op = OP_ALU_OR;
         default: op = OP_ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/instr_decoder.sv
// Pure-combinational RV32I decoder: instruction word + PC in, control
// bundle for the ALU out. Unsupported encodings produce a bundle flagged
// illegal with a neutral ADD, no write-back and a zero immediate.
module instr_decoder
   import params::*;
(
   input  word            instr,
   input  word            pc,
   output decode_bundle_t bundle
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   word        imm_i;
   word        imm_s;
   word        imm_u;
   word        imm_j;
   logic       legal;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

   // Decode the opcode into selects, op-code, immediate and write-enable.
   always_comb begin
      // NOTE: every output gets a default before the case so no path
      // leaves a signal unassigned, which would infer a latch.
      bundle         = '0;
      bundle.pc      = pc;
      bundle.rs1_idx = instr[19:15];
      bundle.rs2_idx = instr[24:20];
      bundle.rd_idx  = instr[11:7];
      bundle.alu_rs1 = ALU_RS1_OP;
      bundle.alu_rs2 = ALU_RS2_OP;
      bundle.alu_op  = OP_ALU_ADD;
      legal          = 1'b1;

      case (opcode)
         OPC_OP: begin
            bundle.rd_we  = 1'b1;
            bundle.alu_op = funct3_to_op(funct3, funct7 == F7_ALT);
            if (funct7 == F7_ALT) legal = (funct3 == 3'b000) || (funct3 == 3'b101);
            else                  legal = (funct7 == F7_ZERO);
         end
         OPC_OP_IMM: begin
            bundle.alu_rs2 = ALU_IMM_OP;
            bundle.imm     = imm_i;
            bundle.rd_we   = 1'b1;
            bundle.alu_op  = funct3_to_op(funct3, (funct3 == 3'b101) && (funct7 == F7_ALT));
            if (funct3 == 3'b001)      legal = (funct7 == F7_ZERO);
            else if (funct3 == 3'b101) legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
         end
         OPC_LUI: begin
            // x0 + imm through the ALU's adder.
            bundle.rs1_idx = 5'd0;
            bundle.alu_rs2 = ALU_IMM_OP;
            bundle.imm     = imm_u;
            bundle.rd_we   = 1'b1;
         end
         OPC_AUIPC: begin
            bundle.alu_rs1 = ALU_PC_OP;
            bundle.alu_rs2 = ALU_IMM_OP;
            bundle.imm     = imm_u;
            bundle.rd_we   = 1'b1;
         end
         OPC_LOAD: begin
            bundle.alu_rs2 = ALU_IMM_OP;
            bundle.imm     = imm_i;
            bundle.rd_we   = 1'b1;
         end
         OPC_STORE: begin
            bundle.alu_rs2 = ALU_IMM_OP;
            bundle.imm     = imm_s;
         end
         OPC_JALR: begin
            // Target address only; execute produces the link value.
            bundle.alu_rs2 = ALU_IMM_OP;
            bundle.imm     = imm_i;
            bundle.rd_we   = 1'b1;
         end
         OPC_JAL: begin
            bundle.alu_rs1 = ALU_PC_OP;
            bundle.alu_rs2 = ALU_IMM_OP;
            bundle.imm     = imm_j;
            bundle.rd_we   = 1'b1;
         end
         default: legal = 1'b0;
      endcase

      if (!legal) begin
         bundle.alu_rs1 = ALU_RS1_OP;
         bundle.alu_rs2 = ALU_RS2_OP;
         bundle.alu_op  = OP_ALU_ADD;
         bundle.imm     = '0;
         bundle.rd_we   = 1'b0;
      end
      bundle.illegal = !legal;
   end

endmodule

// File: rtl/decode_stage.sv
// Pipelined RV32I decode stage: valid/ready in from fetch, registered
// control bundle out to execute, with flush and back-pressure handling.
// Build option DECODE_SKID_EN: two-entry skid buffer with a registered
// in_ready; otherwise a single output register whose in_ready follows
// out_ready combinationally. XLEN must be 32.
module decode_stage
   import params::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_imm,
   output alu_rs1_t        out_alu_rs1,
   output alu_rs2_t        out_alu_rs2,
   output alu_op_t         out_alu_op,
   output logic [4:0]      out_rs1_idx,
   output logic [4:0]      out_rs2_idx,
   output logic [4:0]      out_rd_idx,
   output logic            out_rd_we,
   output logic            out_illegal
);

   decode_bundle_t dec;
   decode_bundle_t main_q;

   instr_decoder u_instr_decoder (
      .instr  (in_instr),
      .pc     (in_pc),
      .bundle (dec)
   );

`ifdef DECODE_SKID_EN

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } occ_t;

   occ_t           state_q;
   occ_t           state_d;
   decode_bundle_t skid_q;
   logic           in_ready_q;
   logic           in_fire;
   logic           out_fire;
   logic           load_main_in;
   logic           load_main_skid;
   logic           load_skid;

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q != EMPTY);
   assign in_fire   = in_valid && in_ready_q;
   assign out_fire  = out_valid && out_ready;

   // Occupancy next-state and buffer load controls; flush empties everything.
   always_comb begin
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  load_main_in = 1'b1;
                  state_d      = ONE;
               end
            end
            ONE: begin
               case ({in_fire, out_fire})
                  2'b11: load_main_in = 1'b1;
                  2'b10: begin
                     load_skid = 1'b1;
                     state_d   = FULL;
                  end
                  2'b01:   state_d = EMPTY;
                  default: state_d = ONE;
               endcase
            end
            FULL: begin
               if (out_fire) begin
                  load_main_skid = 1'b1;
                  state_d        = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   // Occupancy, registered in_ready and the main/skid payload registers.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: the payload registers are reset as well because execute
      // sees them directly and must read an all-zero bundle after reset.
      if (rst) begin
         state_q    <= EMPTY;
         in_ready_q <= 1'b1;
         main_q     <= '0;
         skid_q     <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         state_q    <= state_d;
         in_ready_q <= (state_d != FULL);
         if (load_main_in)        main_q <= dec;
         else if (load_main_skid) main_q <= skid_q;
         if (load_skid)           skid_q <= dec;
      end
   end

`else

   logic valid_q;

   assign out_valid = valid_q;
   assign in_ready  = !rst && (!valid_q || out_ready);

   // Single output register: load on accept, drop on consume or flush.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         main_q  <= '0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (in_valid && in_ready) begin
         valid_q <= 1'b1;
         main_q  <= dec;
      end else if (out_ready) begin
         valid_q <= 1'b0;
      end
   end

`endif

   assign out_pc      = main_q.pc;
   assign out_imm     = main_q.imm;
   assign out_alu_rs1 = main_q.alu_rs1;
   assign out_alu_rs2 = main_q.alu_rs2;
   assign out_alu_op  = main_q.alu_op;
   assign out_rs1_idx = main_q.rs1_idx;
   assign out_rs2_idx = main_q.rs2_idx;
   assign out_rd_idx  = main_q.rd_idx;
   assign out_rd_we   = main_q.rd_we;
   assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a driver pushes the expected bundle
// of each accepted instruction, a negedge monitor checks handshake signals
// every cycle and pops/compares on each output transfer. Works for both
// builds (DECODE_SKID_EN defined or not).
module tb_decode_stage;
   import params::*;

   logic       clk;
   logic       rst;
   logic       flush;
   logic       in_valid;
   logic       in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic       out_valid;
   logic       out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_imm;
   alu_rs1_t   out_alu_rs1;
   alu_rs2_t   out_alu_rs2;
   alu_op_t    out_alu_op;
   logic [4:0] out_rs1_idx;
   logic [4:0] out_rs2_idx;
   logic [4:0] out_rd_idx;
   logic       out_rd_we;
   logic       out_illegal;

   int n_cmp = 0;
   int n_bad = 0;
   bit mon_en = 1'b0;
   decode_bundle_t sb[$];

   decode_stage #(.XLEN(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .in_pc       (in_pc),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_pc      (out_pc),
      .out_imm     (out_imm),
      .out_alu_rs1 (out_alu_rs1),
      .out_alu_rs2 (out_alu_rs2),
      .out_alu_op  (out_alu_op),
      .out_rs1_idx (out_rs1_idx),
      .out_rs2_idx (out_rs2_idx),
      .out_rd_idx  (out_rd_idx),
      .out_rd_we   (out_rd_we),
      .out_illegal (out_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h", name, got, exp);
      end
   endtask

   function automatic decode_bundle_t dut_bundle();
      decode_bundle_t b;
      b.pc      = out_pc;
      b.imm     = out_imm;
      b.alu_rs1 = out_alu_rs1;
      b.alu_rs2 = out_alu_rs2;
      b.alu_op  = out_alu_op;
      b.rs1_idx = out_rs1_idx;
      b.rs2_idx = out_rs2_idx;
      b.rd_idx  = out_rd_idx;
      b.rd_we   = out_rd_we;
      b.illegal = out_illegal;
      return b;
   endfunction

   function automatic decode_bundle_t mk(input word pc, input word imm, input alu_rs1_t s1,
                                         input alu_rs2_t s2, input alu_op_t op, input int r1,
                                         input int r2, input int rd, input bit we, input bit ill);
      decode_bundle_t b;
      b.pc = pc; b.imm = imm; b.alu_rs1 = s1; b.alu_rs2 = s2; b.alu_op = op;
      b.rs1_idx = 5'(r1); b.rs2_idx = 5'(r2); b.rd_idx = 5'(rd);
      b.rd_we = we; b.illegal = ill;
      return b;
   endfunction

   // Reference decode straight from the RV32I field definitions, using
   // integer arithmetic for the immediates.
   function automatic decode_bundle_t ref_decode(input word ins, input word pc);
      decode_bundle_t b;
      alu_op_t tbl [8];
      int iv, sv, jv;
      logic [2:0] f3;
      logic [6:0] f7;
      bit ok;
      tbl = '{OP_ALU_ADD, OP_ALU_SLL, OP_ALU_SLT, OP_ALU_SLTU,
              OP_ALU_XOR, OP_ALU_SRL, OP_ALU_OR, OP_ALU_AND};
      f3 = ins[14:12];
      f7 = ins[31:25];
      iv = int'(ins[31:20]);
      if (iv >= 2048) iv -= 4096;
      sv = int'({ins[31:25], ins[11:7]});
      if (sv >= 2048) sv -= 4096;
      jv = int'(ins[31]) * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
         + int'(ins[30:21]) * 2;
      if (jv >= 1048576) jv -= 2097152;
      b = mk(pc, 0, ALU_RS1_OP, ALU_RS2_OP, OP_ALU_ADD, int'(ins[19:15]), int'(ins[24:20]),
             int'(ins[11:7]), 1'b0, 1'b0);
      ok = 1'b1;
      case (ins[6:0])
         7'b0110011: begin
            b.rd_we = 1'b1;
            b.alu_op = tbl[f3];
            if (f7 == 7'h20) begin
               if (f3 == 3'd0) b.alu_op = OP_ALU_SUB;
               else if (f3 == 3'd5) b.alu_op = OP_ALU_SRA;
               else ok = 1'b0;
            end else if (f7 != 7'h00) ok = 1'b0;
         end
         7'b0010011: begin
            b.rd_we = 1'b1; b.alu_rs2 = ALU_IMM_OP; b.imm = word'(iv); b.alu_op = tbl[f3];
            if (f3 == 3'd1 && f7 != 7'h00) ok = 1'b0;
            if (f3 == 3'd5) begin
               if (f7 == 7'h20) b.alu_op = OP_ALU_SRA;
               else if (f7 != 7'h00) ok = 1'b0;
            end
         end
         7'b0110111: begin
            b.rd_we = 1'b1; b.rs1_idx = 5'd0; b.alu_rs2 = ALU_IMM_OP; b.imm = ins & 32'hFFFFF000;
         end
         7'b0010111: begin
            b.rd_we = 1'b1; b.alu_rs1 = ALU_PC_OP; b.alu_rs2 = ALU_IMM_OP;
            b.imm = ins & 32'hFFFFF000;
         end
         7'b0000011, 7'b1100111: begin
            b.rd_we = 1'b1; b.alu_rs2 = ALU_IMM_OP; b.imm = word'(iv);
         end
         7'b0100011: begin
            b.alu_rs2 = ALU_IMM_OP; b.imm = word'(sv);
         end
         7'b1101111: begin
            b.rd_we = 1'b1; b.alu_rs1 = ALU_PC_OP; b.alu_rs2 = ALU_IMM_OP; b.imm = word'(jv);
         end
         default: ok = 1'b0;
      endcase
      if (!ok) begin
         b.illegal = 1'b1; b.alu_op = OP_ALU_ADD; b.rd_we = 1'b0; b.imm = '0;
         b.alu_rs1 = ALU_RS1_OP; b.alu_rs2 = ALU_RS2_OP;
      end
      return b;
   endfunction

   function automatic word rand_instr();
      logic [6:0] opcs [8];
      word ins;
      int pick;
      opcs = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111,
               7'b0000011, 7'b0100011, 7'b1100111, 7'b1101111};
      ins = $urandom;
      pick = $urandom_range(0, 9);
      if (pick < 8) ins[6:0] = opcs[pick];
      if (pick < 2) begin
         case ($urandom_range(0, 3))
            0, 1:    ins[31:25] = 7'h00;
            2:       ins[31:25] = 7'h20;
            default: ins[31:25] = 7'($urandom);
         endcase
      end
      return ins;
   endfunction

   function automatic bit exp_in_ready();
`ifdef DECODE_SKID_EN
      return sb.size() < 2;
`else
      return (sb.size() == 0) || out_ready;
`endif
   endfunction

   // Offer one instruction and hold it until accepted (bounded).
   task automatic send(input word ins, input word pc, input decode_bundle_t exp);
      bit acc;
      acc = 1'b0;
      in_valid = 1'b1;
      in_instr = ins;
      in_pc    = pc;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk); #1;
         if (in_ready) begin
            sb.push_back(exp);
            acc = 1'b1;
         end
         @(posedge clk); #1;
         if (acc) break;
      end
      in_valid = 1'b0;
      check("send_accepted", acc, 1'b1);
   endtask

   // Monitor: per-cycle handshake checks, pop and compare on each output transfer.
   always @(negedge clk) begin
      decode_bundle_t exp_b;
      if (mon_en && !rst) begin
         check("out_valid", out_valid, sb.size() != 0);
         check("in_ready", in_ready, exp_in_ready());
         if (out_valid && out_ready && !flush && sb.size() != 0) begin
            exp_b = sb.pop_front();
            check("payload", dut_bundle(), exp_b);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got=no_finish expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;

      // Reset state while rst is held.
      #12;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_payload", dut_bundle(), decode_bundle_t'(0));
`ifdef DECODE_SKID_EN
      check("rst_in_ready", in_ready, 1'b1);
`else
      check("rst_in_ready", in_ready, 1'b0);
`endif
      @(negedge clk); #1;
      rst = 1'b0;
      mon_en = 1'b1;
      @(posedge clk); #1;

      // Directed decodes, back-to-back with execute always ready.
      out_ready = 1'b1;
      send(32'hFFF10093, 32'h0,
           mk(32'h0, 32'hFFFFFFFF, ALU_RS1_OP, ALU_IMM_OP, OP_ALU_ADD, 2, 31, 1, 1, 0));
      send(32'h402081B3, 32'h4,
           mk(32'h4, 32'h0, ALU_RS1_OP, ALU_RS2_OP, OP_ALU_SUB, 1, 2, 3, 1, 0));
      send(32'h4030D093, 32'h8,
           mk(32'h8, 32'h403, ALU_RS1_OP, ALU_IMM_OP, OP_ALU_SRA, 1, 3, 1, 1, 0));
      send(32'h00001097, 32'h100,
           mk(32'h100, 32'h1000, ALU_PC_OP, ALU_IMM_OP, OP_ALU_ADD, 0, 0, 1, 1, 0));
      send(32'h123452B7, 32'h104,
           mk(32'h104, 32'h12345000, ALU_RS1_OP, ALU_IMM_OP, OP_ALU_ADD, 0, 3, 5, 1, 0));
      send(32'h00000000, 32'h108,
           mk(32'h108, 32'h0, ALU_RS1_OP, ALU_RS2_OP, OP_ALU_ADD, 0, 0, 0, 0, 1));
      repeat (3) @(posedge clk);
      #1;

      // Back-pressure: three offers with execute stalled, then release.
      out_ready = 1'b0;
      fork
         begin
            send(32'h00500093, 32'h200, ref_decode(32'h00500093, 32'h200));
            send(32'h00A00113, 32'h204, ref_decode(32'h00A00113, 32'h204));
            send(32'h002081B3, 32'h208, ref_decode(32'h002081B3, 32'h208));
         end
         begin
            repeat (6) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      repeat (4) @(posedge clk);
      #1;

      // Flush while the buffer is full and an input is offered.
      out_ready = 1'b0;
      send(32'h00100093, 32'h300, ref_decode(32'h00100093, 32'h300));
`ifdef DECODE_SKID_EN
      send(32'h00200093, 32'h304, ref_decode(32'h00200093, 32'h304));
`endif
      in_valid = 1'b1; in_instr = 32'h00300093; in_pc = 32'h308; flush = 1'b1;
      @(negedge clk); #1;
      sb.delete();
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk); #1;
      check("flush_clears_valid", out_valid, 1'b0);
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // Randomized traffic with random back-pressure and occasional flush.
      fork
         begin
            for (int c = 0; c < 400; c++) begin
               @(posedge clk); #1;
               in_valid = ($urandom_range(0, 3) != 0);
               flush    = ($urandom_range(0, 39) == 0);
               in_instr = rand_instr();
               in_pc    = $urandom & 32'hFFFFFFFC;
               @(negedge clk); #1;
               if (flush) sb.delete();
               else if (in_valid && in_ready) sb.push_back(ref_decode(in_instr, in_pc));
            end
         end
         begin
            for (int c = 0; c < 400; c++) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (sb.size() == 0) break;
         @(posedge clk);
      end
      #1;
      check("drain_empty", sb.size(), 0);

      // Asynchronous reset mid-stream with a bundle held at the output.
      out_ready = 1'b0;
      send(32'h00C00293, 32'h400, ref_decode(32'h00C00293, 32'h400));
      @(posedge clk); #1;
      check("pre_rst_valid", out_valid, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_valid", out_valid, 1'b0);
      check("async_rst_payload", dut_bundle(), decode_bundle_t'(0));
`ifdef DECODE_SKID_EN
      check("async_rst_in_ready", in_ready, 1'b1);
`else
      check("async_rst_in_ready", in_ready, 1'b0);
`endif
      sb.delete();
      @(negedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(32'h00700393, 32'h500, ref_decode(32'h00700393, 32'h500));
      repeat (3) @(posedge clk);
      #1;
      check("final_empty", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
